// File: rtl/snake_food_gen_pkg.sv
`default_nettype none
// snake_food_gen_pkg: shared constants, FSM encoding and coordinate helpers for the food generator.
// rev 1.0
package snake_food_gen_pkg;

  localparam int          CELL_PX     = 10;
  localparam int          ROW_STRIDE  = 80;
  localparam int          CELL_W      = 14;
  localparam int          PIX_W       = 10;
  localparam int          DEF_COL_MIN = 20;
  localparam int          DEF_COL_MAX = 77;
  localparam int          DEF_ROW_MIN = 9;
  localparam int          DEF_ROW_MAX = 46;
  localparam logic [15:0] DEF_SEED    = 16'hACE1;
  // Taps 16,14,13,11 of the polynomial map to state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {
    ST_GEN  = 2'd0,
    ST_QRY  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic [CELL_W-1:0] cell_index(input logic [6:0] col, input logic [5:0] row);
    return CELL_W'(col) * CELL_W'(ROW_STRIDE) + CELL_W'(row);
  endfunction

  function automatic logic [PIX_W-1:0] pixel_coord(input logic [6:0] idx);
    return PIX_W'(idx) * PIX_W'(CELL_PX) + PIX_W'(5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_food_gen_if.sv
`default_nettype none
// snake_food_gen_if: occupancy query handshake, eaten strobe and food outputs.
// rev 1.0
interface snake_food_gen_if;
  import snake_food_gen_pkg::*;

  logic              query_req;
  logic [CELL_W-1:0] query_cell;
  logic              query_hit;
  logic              eaten;
  logic [PIX_W-1:0]  food_x;
  logic [PIX_W-1:0]  food_y;
  logic [CELL_W-1:0] food_cell;
  logic              food_valid;
  logic [7:0]        attempts;

  modport master (
    output query_req, query_cell, food_x, food_y, food_cell, food_valid, attempts,
    input  query_hit, eaten
  );

  modport slave (
    input  query_req, query_cell, food_x, food_y, food_cell, food_valid, attempts,
    output query_hit, eaten
  );
endinterface
`default_nettype wire

// File: rtl/snake_lfsr16.sv
`default_nettype none
// snake_lfsr16: free-running 16-bit Fibonacci LFSR, seed reloaded on reset.
// rev 1.0
module snake_lfsr16
  import snake_food_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEF_SEED,
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= SEED;
    else          r_state <= {r_state[14:0], ^(r_state & TAPS)};
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/snake_food_gen.sv
`default_nettype none
// snake_food_gen: proposes LFSR cells, filters by playfield and snake occupancy, holds food until eaten.
// rev 1.0
module snake_food_gen
  import snake_food_gen_pkg::*;
#(
  parameter logic [15:0] SEED    = DEF_SEED,
  parameter int          COL_MIN = DEF_COL_MIN,
  parameter int          COL_MAX = DEF_COL_MAX,
  parameter int          ROW_MIN = DEF_ROW_MIN,
  parameter int          ROW_MAX = DEF_ROW_MAX
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  snake_food_gen_if.master bus
);

  logic [15:0]       w_lfsr;
  logic [6:0]        w_cand_col;
  logic [5:0]        w_cand_row;
  logic              w_in_range;
  state_t            r_state;
  state_t            w_state_next;
  logic [6:0]        r_col;
  logic [5:0]        r_row;
  logic [PIX_W-1:0]  r_food_x;
  logic [PIX_W-1:0]  r_food_y;
  logic [CELL_W-1:0] r_food_cell;
  logic              r_food_valid;
  logic [7:0]        r_attempts;

  snake_lfsr16 #(.SEED(SEED), .TAPS(LFSR_TAPS)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_state (w_lfsr)
  );

  assign w_cand_col = w_lfsr[6:0];
  assign w_cand_row = w_lfsr[13:8];
  assign w_in_range = (int'(w_cand_col) >= COL_MIN) && (int'(w_cand_col) <= COL_MAX) &&
                      (int'(w_cand_row) >= ROW_MIN) && (int'(w_cand_row) <= ROW_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_GEN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_GEN:  if (w_in_range) w_state_next = ST_QRY;
      ST_QRY:  w_state_next = ST_WAIT;
      ST_WAIT: w_state_next = bus.query_hit ? ST_GEN : ST_HOLD;
      ST_HOLD: if (bus.eaten) w_state_next = ST_GEN;
      default: w_state_next = ST_GEN;
    endcase
  end

  // Food coordinates only move on a successful WAIT; they persist through regeneration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_food_x     <= '0;
      r_food_y     <= '0;
      r_food_cell  <= '0;
      r_food_valid <= 1'b0;
      r_attempts   <= '0;
    end else begin
      case (r_state)
        ST_GEN: begin
          if (w_in_range) begin
            r_col <= w_cand_col;
            r_row <= w_cand_row;
          end
        end
        ST_WAIT: begin
          if (bus.query_hit) begin
            if (r_attempts != 8'hFF) r_attempts <= r_attempts + 8'd1;
          end else begin
            r_food_x     <= pixel_coord(r_col);
            r_food_y     <= pixel_coord({1'b0, r_row});
            r_food_cell  <= cell_index(r_col, r_row);
            r_food_valid <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.eaten) begin
            r_food_valid <= 1'b0;
            r_attempts   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.query_req  = (r_state == ST_QRY);
  assign bus.query_cell = cell_index(r_col, r_row);
  assign bus.food_x     = r_food_x;
  assign bus.food_y     = r_food_y;
  assign bus.food_cell  = r_food_cell;
  assign bus.food_valid = r_food_valid;
  assign bus.attempts   = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_snake_food_gen.sv
`default_nettype none
// tb_snake_food_gen: directed scenarios against a reference LFSR placement model.
// rev 1.0
module tb_snake_food_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  int          q_count;
  int          hit_until = 0;
  int          dbl_req   = 0;
  logic        prev_req  = 1'b0;
  logic [15:0] m_lfsr;
  int          s1_e, s1_x, s1_y;

  snake_food_gen_if u_if ();

  snake_food_gen u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic bit in_range(input logic [15:0] s);
    int c, r;
    c = int'(s[6:0]);
    r = int'(s[13:8]);
    return (c >= 20) && (c <= 77) && (r >= 9) && (r <= 46);
  endfunction

  // Edges from GEN entry until valid, given the LFSR value at GEN entry and the hits to absorb.
  function automatic void predict(input logic [15:0] s0, input int hits,
                                  output int edges, output int col, output int row);
    logic [15:0] s;
    int h;
    s = s0; h = 0; edges = 0; col = 0; row = 0;
    for (int guard = 0; guard < 1000000; guard++) begin
      if (in_range(s)) begin
        col = int'(s[6:0]);
        row = int'(s[13:8]);
        s = step(step(step(s)));
        edges += 3;
        if (h == hits) break;
        h++;
      end else begin
        s = step(s);
        edges++;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= step(m_lfsr);
  end

  // Body-store responder: answers the cycle after each query.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_count        <= 0;
      u_if.query_hit <= 1'b0;
    end else if (u_if.query_req) begin
      q_count        <= q_count + 1;
      u_if.query_hit <= (q_count < hit_until);
    end else begin
      u_if.query_hit <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (prev_req && u_if.query_req) dbl_req <= dbl_req + 1;
    prev_req <= u_if.query_req;
  end

  task automatic eat_edge();
    @(negedge clk) u_if.eaten = 1'b1;
    @(posedge clk); #1;
    u_if.eaten = 1'b0;
  endtask

  task automatic test_reset();
    u_if.eaten = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++;
    if ({u_if.food_x, u_if.food_y, u_if.food_cell} !== 34'd0)
      $display("FAIL reset_coords got=%h want=0", {u_if.food_x, u_if.food_y, u_if.food_cell});
    total++;
    if ({u_if.food_valid, u_if.attempts} !== 9'd0) begin
      bad++; $display("FAIL reset_valid_att got=%h want=0", {u_if.food_valid, u_if.attempts});
    end
    total++;
    if ({u_if.query_req, u_if.query_cell} !== 15'd0) begin
      bad++; $display("FAIL reset_query got=%h want=0", {u_if.query_req, u_if.query_cell});
    end
    if ({u_if.food_x, u_if.food_y, u_if.food_cell} !== 34'd0) bad++;
  endtask

  task automatic test_first();
    int e, c, r;
    @(negedge clk) rst_n = 1'b1;
    predict(16'hACE1, 0, e, c, r);
    repeat (e - 2) @(posedge clk); #1;
    total++;
    if (u_if.query_req !== 1'b1 || u_if.query_cell !== 14'(c * 80 + r)) begin
      bad++; $display("FAIL first_query got=%0d/%0d want=1/%0d", u_if.query_req, u_if.query_cell, c * 80 + r);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b0) begin
      bad++; $display("FAIL first_early_valid got=%0d want=0", u_if.food_valid);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b1 || u_if.food_x !== 10'(c * 10 + 5) || u_if.food_y !== 10'(r * 10 + 5)) begin
      bad++; $display("FAIL first_place got=%0d,%0d,%0d want=1,%0d,%0d",
                      u_if.food_valid, u_if.food_x, u_if.food_y, c * 10 + 5, r * 10 + 5);
    end
    total++;
    if (u_if.food_x % 10 != 5 || u_if.food_cell !== 14'((u_if.food_x / 10) * 80 + u_if.food_y / 10)
        || u_if.attempts !== 8'd0) begin
      bad++; $display("FAIL first_cell got=%0d att=%0d want=%0d att=0", u_if.food_cell, u_if.attempts, c * 80 + r);
    end
    s1_e = e; s1_x = c * 10 + 5; s1_y = r * 10 + 5;
  endtask

  task automatic test_hits();
    int e, c, r, q0;
    q0 = q_count;
    hit_until = q0 + 3;
    eat_edge();
    predict(m_lfsr, 3, e, c, r);
    repeat (e - 1) @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b0) begin
      bad++; $display("FAIL hits_early_valid got=%0d want=0", u_if.food_valid);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b1 || u_if.attempts !== 8'd3 || u_if.food_cell !== 14'(c * 80 + r)) begin
      bad++; $display("FAIL hits_place got=%0d,%0d,%0d want=1,3,%0d",
                      u_if.food_valid, u_if.attempts, u_if.food_cell, c * 80 + r);
    end
    total++;
    if (q_count - q0 != 4) begin
      bad++; $display("FAIL hits_queries got=%0d want=4", q_count - q0);
    end
  endtask

  task automatic test_eaten_pulse();
    int e, c, r;
    logic [9:0]  ox, oy;
    logic [13:0] oc;
    ox = u_if.food_x; oy = u_if.food_y; oc = u_if.food_cell;
    eat_edge();
    total++;
    if (u_if.food_valid !== 1'b0 || u_if.attempts !== 8'd0) begin
      bad++; $display("FAIL eat_clear got=%0d,%0d want=0,0", u_if.food_valid, u_if.attempts);
    end
    predict(m_lfsr, 0, e, c, r);
    repeat (e - 1) @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b0 || u_if.food_x !== ox || u_if.food_y !== oy || u_if.food_cell !== oc) begin
      bad++; $display("FAIL eat_hold_old got=%0d,%0d,%0d want=0,%0d,%0d", u_if.food_valid, u_if.food_x, u_if.food_y, ox, oy);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b1 || u_if.food_cell !== 14'(c * 80 + r)) begin
      bad++; $display("FAIL eat_replace got=%0d,%0d want=1,%0d", u_if.food_valid, u_if.food_cell, c * 80 + r);
    end
  endtask

  task automatic test_eaten_held();
    int e, c, r;
    @(negedge clk) u_if.eaten = 1'b1;
    @(posedge clk); #1;
    predict(m_lfsr, 0, e, c, r);
    repeat (e - 1) @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b0) begin
      bad++; $display("FAIL held_early_valid got=%0d want=0", u_if.food_valid);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b1 || u_if.food_cell !== 14'(c * 80 + r)) begin
      bad++; $display("FAIL held_place got=%0d,%0d want=1,%0d", u_if.food_valid, u_if.food_cell, c * 80 + r);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b0) begin
      bad++; $display("FAIL held_restart got=%0d want=0", u_if.food_valid);
    end
    u_if.eaten = 1'b0;
    predict(m_lfsr, 0, e, c, r);
    repeat (e) @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b1 || u_if.food_cell !== 14'(c * 80 + r)) begin
      bad++; $display("FAIL held_next got=%0d,%0d want=1,%0d", u_if.food_valid, u_if.food_cell, c * 80 + r);
    end
  endtask

  task automatic test_reset_mid();
    int e, c, r;
    hit_until = 0;
    eat_edge();
    predict(m_lfsr, 0, e, c, r);
    repeat (e - 1) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({u_if.food_x, u_if.food_y, u_if.food_cell, u_if.food_valid, u_if.attempts,
         u_if.query_req, u_if.query_cell} !== 58'd0) begin
      bad++; $display("FAIL async_reset got=%0d,%0d,%0d,%0d want=0", u_if.food_x, u_if.food_y, u_if.food_cell, u_if.query_cell);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (s1_e - 1) @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b0) begin
      bad++; $display("FAIL rerun_early_valid got=%0d want=0", u_if.food_valid);
    end
    @(posedge clk); #1;
    total++;
    if (u_if.food_valid !== 1'b1 || u_if.food_x !== 10'(s1_x) || u_if.food_y !== 10'(s1_y)) begin
      bad++; $display("FAIL rerun_place got=%0d,%0d,%0d want=1,%0d,%0d", u_if.food_valid, u_if.food_x, u_if.food_y, s1_x, s1_y);
    end
  endtask

  task automatic test_saturate();
    bit found;
    found = 1'b0;
    hit_until = q_count + 300;
    eat_edge();
    for (int cyc = 0; cyc < 30000 && !found; cyc++) begin
      @(posedge clk); #1;
      if (u_if.food_valid) found = 1'b1;
    end
    total++;
    if (!found || u_if.attempts !== 8'd255) begin
      bad++; $display("FAIL saturate got=%0d found=%0d want=255", u_if.attempts, found);
    end
    hit_until = 0;
  endtask

  task automatic test_sweep();
    int placed, bad_cells, col, row;
    placed = 0; bad_cells = 0;
    u_if.eaten = 1'b1;
    for (int cyc = 0; cyc < 60000 && placed < 2000; cyc++) begin
      @(posedge clk); #1;
      if (u_if.food_valid) begin
        placed++;
        col = (int'(u_if.food_x) - 5) / 10;
        row = (int'(u_if.food_y) - 5) / 10;
        if (u_if.food_x % 10 != 5 || u_if.food_y % 10 != 5 || col < 20 || col > 77 ||
            row < 9 || row > 46 || u_if.food_cell !== 14'(col * 80 + row)) bad_cells++;
      end
    end
    u_if.eaten = 1'b0;
    total++;
    if (placed != 2000) begin
      bad++; $display("FAIL sweep_timeout got=%0d want=2000", placed);
    end
    total++;
    if (bad_cells != 0) begin
      bad++; $display("FAIL sweep_bounds got=%0d want=0", bad_cells);
    end
    total++;
    if (dbl_req != 0) begin
      bad++; $display("FAIL query_pulse_width got=%0d want=0", dbl_req);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_hits();
    test_eaten_pulse();
    test_eaten_held();
    test_reset_mid();
    test_saturate();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
